// File: rtl/ttlock_sweep_ctrl.sv
// ttlock_sweep_ctrl: steps a locked circuit and its unlocked oracle through a
// range of protected-input patterns under one candidate key. It counts the
// output disagreements and remembers the first disagreeing pattern.
// Optional macro TTLOCK_SWEEP_EARLY_STOP_EN: end the sweep on the first
// disagreement instead of sweeping the whole range.
module ttlock_sweep_ctrl #(
  parameter int WKEY   = 32,
  parameter int WINPUT = 32,
  parameter int WCNT   = 32,
  localparam int WOTH  = (WINPUT - WKEY > 0) ? (WINPUT - WKEY) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [WKEY-1:0] cfg_key,
  input  logic [WOTH-1:0] cfg_other,
  input  logic [WKEY-1:0] cfg_first,
  input  logic [WKEY-1:0] cfg_last,
  output logic [WKEY-1:0] protected_o,
  output logic [WKEY-1:0] key_o,
  output logic [WOTH-1:0] other_o,
  input  logic            locked_out_i,
  input  logic            oracle_out_i,
  output logic            busy,
  output logic            done,
  output logic [WCNT-1:0] mismatch_cnt,
  output logic [WKEY-1:0] first_mm_pat,
  output logic            first_mm_valid
);

`ifdef TTLOCK_SWEEP_EARLY_STOP_EN
  localparam bit EARLY_STOP = 1'b1;
`else
  localparam bit EARLY_STOP = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WKEY-1:0] prot_q, prot_d;
  logic [WKEY-1:0] key_q, key_d;
  logic [WOTH-1:0] other_q, other_d;
  logic [WKEY-1:0] last_q, last_d;
  logic [WCNT-1:0] cnt_q, cnt_d;
  logic [WKEY-1:0] fpat_q, fpat_d;
  logic            fvalid_q, fvalid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            mm;
  logic            stop;

  // Next-state and datapath: capture on start, compare/advance while sweeping.
  always_comb begin
    state_d  = state_q;
    prot_d   = prot_q;
    key_d    = key_q;
    other_d  = other_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    fpat_d   = fpat_q;
    fvalid_d = fvalid_q;
    busy_d   = busy_q;
    done_d   = done_q;
    mm       = locked_out_i ^ oracle_out_i;
    stop     = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // start takes priority over a simultaneous abort, which is meaningless here
        if (start) begin
          state_d  = ST_SWEEP;
          prot_d   = cfg_first;
          key_d    = cfg_key;
          other_d  = cfg_other;
          last_d   = cfg_last;
          cnt_d    = '0;
          fpat_d   = '0;
          fvalid_d = 1'b0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
        end
      end
      ST_SWEEP: begin
        // the compare of the current pattern always counts, even on abort
        if (mm) begin
          if (cnt_q != {WCNT{1'b1}}) cnt_d = cnt_q + WCNT'(1);
          if (!fvalid_q) begin
            fpat_d   = prot_q;
            fvalid_d = 1'b1;
          end
        end
        stop = abort || (prot_q == last_q) || (EARLY_STOP && mm);
        if (stop) begin
          // pattern register holds so the host can see where the sweep ended
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          prot_d = prot_q + WKEY'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset that overrides everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      prot_q   <= '0;
      key_q    <= '0;
      other_q  <= '0;
      last_q   <= '0;
      cnt_q    <= '0;
      fpat_q   <= '0;
      fvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prot_q   <= prot_d;
      key_q    <= key_d;
      other_q  <= other_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      fpat_q   <= fpat_d;
      fvalid_q <= fvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign protected_o    = prot_q;
  assign key_o          = key_q;
  assign other_o        = other_q;
  assign mismatch_cnt   = cnt_q;
  assign first_mm_pat   = fpat_q;
  assign first_mm_valid = fvalid_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule
